// File: rtl/spi_host_burst.sv
// spi_host_burst: SPI host that moves bursts of DATA_W-bit words with a
// per-burst latched mode, bit order, clock divider and slave select.
module spi_host_burst #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 8,
  localparam int SS_W  = $clog2(NUM_SS) + 1,
  localparam int EW    = $clog2(2 * DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [SS_W-1:0]   ss_idx,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_SS-1:0] spi_ss_n,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [LEN_W-1:0]  word_count
);
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, STALL, CLEANUP} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [SS_W-1:0] ss_q, ss_d;
  logic [LEN_W-1:0] len_q, len_d, wc_q, wc_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tsh_q, tsh_d, rsh_q, rsh_d, rxd_q, rxd_d;
  logic mosi_q, mosi_d, sclk_q, sclk_d, rxv_q, rxv_d;
  logic [NUM_SS-1:0] ssn_q, ssn_d;
  logic busy_q, busy_d, done_q, done_d, abt_q, abt_d, err_q, err_d, apend_q, apend_d;
  logic tick, last, lead, deliver;

  always_comb begin
    state_d = state_q;
    div_d = div_q; cpol_d = cpol_q; cpha_d = cpha_q; lsb_d = lsb_q; ss_d = ss_q; len_d = len_q;
    cnt_d = cnt_q; edge_d = edge_q; tsh_d = tsh_q; rsh_d = rsh_q; rxd_d = rxd_q;
    mosi_d = mosi_q; sclk_d = sclk_q; wc_d = wc_q;
    rxv_d = (rxv_q && rx_ready) ? 1'b0 : rxv_q;
    err_d = 1'b0;
    deliver = 1'b0;
    tick = state_q == SHIFT && cnt_q == div_q;
    last = edge_q == EW'(2 * DATA_W - 1);
    lead = ~edge_q[0];
    case (state_q)
      IDLE: if (start) begin
        if (ss_idx < SS_W'(NUM_SS) && burst_len != '0) begin
          div_d = cfg_div; cpol_d = cfg_cpol; cpha_d = cfg_cpha; lsb_d = cfg_lsb_first;
          ss_d = ss_idx; len_d = burst_len; wc_d = '0; state_d = SETUP;
        end else err_d = 1'b1;
      end
      SETUP: state_d = LOAD;
      LOAD: if (tx_valid) begin
        tsh_d = tx_data;
        mosi_d = cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        mosi_d = lsb_q ? tx_data[0] : tx_data[DATA_W-1];
        cnt_d = '0; edge_d = '0; state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          // sampling edge is leading for CPHA=0, trailing for CPHA=1; the
          // first bit is already on mosi from LOAD so edge 0 never shifts
          if (lead != cpha_q) rsh_d = lsb_q ? {spi_miso, rsh_q[DATA_W-1:1]} : {rsh_q[DATA_W-2:0], spi_miso};
          else if (edge_q != '0 && !last) begin
            tsh_d = lsb_q ? tsh_q >> 1 : tsh_q << 1;
            mosi_d = lsb_q ? tsh_d[0] : tsh_d[DATA_W-1];
          end
          if (last) begin
            if (!rxv_q || rx_ready) deliver = 1'b1;
            else state_d = STALL;
          end
        end
      end
      STALL: deliver = rx_ready;
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q inside {SETUP, LOAD, SHIFT, STALL} && !(tick && last)) state_d = CLEANUP;
    if (deliver) begin
      rxd_d = rsh_d; rxv_d = 1'b1; wc_d = wc_q + 1'b1;
      state_d = (abort || apend_q || wc_d >= len_q) ? CLEANUP : LOAD;
    end
    apend_d = state_d == IDLE ? 1'b0 : (apend_q || (state_d == STALL && state_q == SHIFT && abort));
    if (!(state_d inside {SHIFT, STALL})) sclk_d = cpol_d;
    ssn_d = (state_d inside {SETUP, LOAD, SHIFT, STALL}) ? ~(NUM_SS'(1) << ss_d) : '1;
    busy_d = state_d != IDLE;
    done_d = state_d == CLEANUP && state_q != CLEANUP;
    abt_d = done_d && (abort || apend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0; cpol_q <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; ss_q <= '0; len_q <= '0;
      cnt_q <= '0; edge_q <= '0; tsh_q <= '0; rsh_q <= '0; rxd_q <= '0;
      mosi_q <= 1'b0; sclk_q <= 1'b0; rxv_q <= 1'b0; wc_q <= '0; ssn_q <= '1;
      busy_q <= 1'b0; done_q <= 1'b0; abt_q <= 1'b0; err_q <= 1'b0; apend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d; cpol_q <= cpol_d; cpha_q <= cpha_d; lsb_q <= lsb_d; ss_q <= ss_d; len_q <= len_d;
      cnt_q <= cnt_d; edge_q <= edge_d; tsh_q <= tsh_d; rsh_q <= rsh_d; rxd_q <= rxd_d;
      mosi_q <= mosi_d; sclk_q <= sclk_d; rxv_q <= rxv_d; wc_q <= wc_d; ssn_q <= ssn_d;
      busy_q <= busy_d; done_q <= done_d; abt_q <= abt_d; err_q <= err_d; apend_q <= apend_d;
    end
  end

  assign tx_ready = state_q == LOAD;
  assign rx_data = rxd_q;
  assign rx_valid = rxv_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ssn_q;
  assign busy = busy_q;
  assign done = done_q;
  assign aborted = abt_q;
  assign err = err_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_spi_host_burst.sv
// tb_spi_host_burst: directed bursts with a loopback/tied MISO slave and an
// RX scoreboard fed from the words queued for transmission.
module tb_spi_host_burst;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cfg_div = '0, burst_len = '0, tx_data = '0, rx_data, word_count;
  logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [2:0] ss_idx = '0;
  logic start = 1'b0, abort = 1'b0, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b1;
  logic spi_sclk, spi_mosi, spi_miso, busy, done, aborted, err;
  logic [3:0] spi_ss_n;
  logic miso_one = 1'b0, tx_take = 1'b0;
  logic [7:0] txq[$], exp_q[$];
  int n_chk = 0, n_fail = 0;
  int edges = 0, first_e = 0, last_e = 0, ss_tog = 0, rx_seen = 0, cyc = 0, e1;
  logic sclk_prev = 1'b0;
  logic [3:0] ssn_prev = 4'hf, ss_low = 4'hf;
  bit ab;

  spi_host_burst dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .ss_idx(ss_idx), .burst_len(burst_len), .start(start),
    .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n), .busy(busy), .done(done),
    .aborted(aborted), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  assign spi_miso = miso_one ? 1'b1 : spi_mosi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) tx_take = tx_ready && tx_valid;
  always @(posedge clk) begin
    if (tx_take && !rst && txq.size() != 0) void'(txq.pop_front());
    #1;
    tx_valid = txq.size() != 0;
    tx_data = tx_valid ? txq[0] : 8'h00;
  end

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst && rx_valid && rx_ready) begin
      e = 32'hdead_beef;
      if (exp_q.size() != 0) e = 32'(exp_q.pop_front());
      rx_seen++;
      chk("rx_data", 32'(rx_data), e);
    end
    if (spi_sclk !== sclk_prev && ssn_prev != 4'hf) begin
      edges++;
      if (edges == 1) first_e = cyc;
      last_e = cyc;
    end
    if (spi_ss_n !== ssn_prev) ss_tog++;
    if (spi_ss_n != 4'hf) ss_low = spi_ss_n;
    sclk_prev = spi_sclk;
    ssn_prev = spi_ss_n;
    cyc++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_mon();
    edges = 0; ss_tog = 0; rx_seen = 0;
  endtask

  // config is scrambled right after start to show the burst uses latched values
  task automatic burst(input logic pol, pha, lsb, input logic [7:0] div, input logic [2:0] ss, input logic [7:0] len);
    cfg_cpol = pol; cfg_cpha = pha; cfg_lsb_first = lsb; cfg_div = div; ss_idx = ss; burst_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_cpol = ~pol; cfg_cpha = ~pha; cfg_lsb_first = ~lsb; cfg_div = div + 8'd3; ss_idx = ss ^ 3'd1; burst_len = len + 8'd2;
  endtask

  task automatic wait_done(input int lim, output bit abv);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", 32'(done), 1);
    abv = aborted;
  endtask

  initial begin
    #12;
    chk("rst_sclk", 32'(spi_sclk), 0);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_ss_n", 32'(spi_ss_n), 'hf);
    chk("rst_flags", {rx_valid, tx_ready, busy, done, aborted, err}, 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    step(2);
    // mode 0, div 1, slave 2, loopback
    clr_mon();
    txq.push_back(8'ha5); exp_q.push_back(8'ha5);
    burst(1'b0, 1'b0, 1'b0, 8'd1, 3'd2, 8'd1);
    wait_done(200, ab);
    chk("a_ss_n_done", 32'(spi_ss_n), 'hf);
    chk("a_wc", 32'(word_count), 1);
    chk("a_aborted", 32'(ab), 0);
    step();
    chk("a_ss_low", 32'(ss_low), 'hb);
    chk("a_edges", edges, 16);
    chk("a_span", last_e - first_e, 30);
    chk("a_sclk_idle", 32'(spi_sclk), 0);
    chk("a_busy_after", {busy, done}, 0);
    chk("a_rx_seen", rx_seen, 1);
    // mode 3, lsb first, 3 words, MISO tied high
    miso_one = 1'b1; clr_mon();
    txq.push_back(8'h01); txq.push_back(8'h80); txq.push_back(8'h3c);
    repeat (3) exp_q.push_back(8'hff);
    burst(1'b1, 1'b1, 1'b1, 8'd0, 3'd1, 8'd3);
    wait_done(400, ab);
    chk("b_wc", 32'(word_count), 3);
    step();
    chk("b_rx_seen", rx_seen, 3);
    chk("b_ss_tog", ss_tog, 2);
    chk("b_ss_low", 32'(ss_low), 'hd);
    chk("b_edges", edges, 48);
    chk("b_sclk_idle", 32'(spi_sclk), 1);
    // RX back-pressure stalls the second word
    miso_one = 1'b0; rx_ready = 1'b0; clr_mon();
    txq.push_back(8'h11); txq.push_back(8'h22); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    burst(1'b0, 1'b0, 1'b0, 8'd2, 3'd0, 8'd2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_valid) break;
    end
    chk("c_rx_valid_w1", 32'(rx_valid), 1);
    step(100);
    chk("c_edges_stall", edges, 32);
    chk("c_sclk_stall", 32'(spi_sclk), 0);
    chk("c_ss_stall", 32'(spi_ss_n), 'he);
    chk("c_busy_wc", {busy, word_count}, 'h101);
    e1 = edges;
    step(10);
    chk("c_stall_hold", edges, e1);
    rx_ready = 1'b1;
    wait_done(50, ab);
    chk("c_wc", 32'(word_count), 2);
    step();
    chk("c_rx_seen", rx_seen, 2);
    // illegal starts
    burst(1'b0, 1'b0, 1'b0, 8'd1, 3'd4, 8'd1);
    chk("d_err_ss", {err, busy, spi_ss_n}, 'h2f);
    step();
    chk("d_err_clear", 32'(err), 0);
    burst(1'b0, 1'b0, 1'b0, 8'd1, 3'd0, 8'd0);
    chk("d_err_len", {err, busy, spi_ss_n}, 'h2f);
    step();
    chk("d_idle", {err, busy}, 0);
    // abort in the middle of word 2 of 4
    clr_mon();
    txq.push_back(8'hc3); txq.push_back(8'h3c); txq.push_back(8'hf0); txq.push_back(8'h0f);
    exp_q.push_back(8'hc3);
    burst(1'b0, 1'b0, 1'b0, 8'd1, 3'd3, 8'd4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (word_count == 8'd1) break;
    end
    chk("e_wc1", 32'(word_count), 1);
    step(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("e_ss_n", 32'(spi_ss_n), 'hf);
    chk("e_done_abt", {done, aborted}, 3);
    chk("e_wc", 32'(word_count), 1);
    chk("e_rx_valid", 32'(rx_valid), 0);
    step();
    chk("e_done_clear", {done, aborted, busy}, 0);
    step(20);
    chk("e_rx_seen", rx_seen, 1);
    txq.delete();
    // asynchronous reset mid-word, then a fresh mode-1 transfer
    clr_mon();
    txq.push_back(8'he0); txq.push_back(8'h77);
    burst(1'b0, 1'b0, 1'b0, 8'd3, 3'd1, 8'd2);
    step(14);
    chk("f_pre_sclk_mosi", {spi_sclk, spi_mosi}, 3);
    #2 rst = 1'b1;
    #1;
    chk("f_sclk", 32'(spi_sclk), 0);
    chk("f_mosi", 32'(spi_mosi), 0);
    chk("f_ss_n", 32'(spi_ss_n), 'hf);
    chk("f_flags", {rx_valid, tx_ready, busy, done, aborted, err}, 0);
    chk("f_wc", 32'(word_count), 0);
    txq.delete(); exp_q.delete();
    step(3);
    rst = 1'b0;
    step(2);
    clr_mon();
    txq.push_back(8'h5a); exp_q.push_back(8'h5a);
    burst(1'b0, 1'b1, 1'b0, 8'd0, 3'd3, 8'd1);
    wait_done(200, ab);
    chk("f2_wc", 32'(word_count), 1);
    step();
    chk("f2_edges", edges, 16);
    chk("f2_rx_seen", rx_seen, 1);
    chk("f2_ss_low", 32'(ss_low), 'h7);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
